// File: rtl/mhd_stream_monitor.sv
// mhd_stream_monitor: pipelined Hamming-distance error monitor for exact/approximate word pairs.
// Two-stage datapath (XOR, popcount+compare) feeding saturating run statistics.
`default_nettype none

module mhd_stream_monitor #(
  parameter  int WIDTH = 9,
  parameter  int MHD   = 1,
  parameter  int CNT_W = 16,
  parameter  int SUM_W = 24,
  localparam int HDW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [HDW-1:0]   thr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             f_valid,
  output logic             f,
  output logic [HDW-1:0]   hd,
  output logic             busy,
  output logic             done,
  output logic             any_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HDW-1:0]   max_hd,
  output logic [SUM_W-1:0] hd_sum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [HDW-1:0]   r_thr;
  logic             r_s1_v, r_s1_last;
  logic [WIDTH-1:0] r_s1_x;
  logic             r_fv, r_f, r_s2_last, r_done, r_any;
  logic [HDW-1:0]   r_hd, r_max;
  logic [CNT_W-1:0] r_cnt, r_err;
  logic [SUM_W-1:0] r_sum;

  logic             w_accept, w_start, w_viol;
  logic [HDW-1:0]   w_pop;
  logic [SUM_W:0]   w_sum_ext;

  assign in_ready = (r_state == S_RUN);
  assign w_accept = in_valid & in_ready;
  // start is honoured only from IDLE; DRAIN holds through the done cycle so a coincident start is dropped
  assign w_start  = start & (r_state == S_IDLE);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + HDW'(r_s1_x[i]);
    end
  end

  assign w_viol    = (w_pop > r_thr);
  assign w_sum_ext = {1'b0, r_sum} + (SUM_W + 1)'(r_hd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_thr   <= HDW'(MHD);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_thr   <= thr;
          end
        end
        S_RUN:   if (w_accept && in_last) r_state <= S_DRAIN;
        S_DRAIN: if (r_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_x    <= '0;
      r_fv      <= 1'b0;
      r_f       <= 1'b0;
      r_hd      <= '0;
      r_s2_last <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_s1_v    <= w_accept;
      r_s1_last <= w_accept & in_last;
      if (w_accept) r_s1_x <= a ^ b;
      r_fv      <= r_s1_v;
      r_s2_last <= r_s1_v & r_s1_last;
      if (r_s1_v) begin
        r_hd <= w_pop;
        r_f  <= w_viol;
      end
      r_done    <= r_fv & r_s2_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_any <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_err <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_any <= 1'b0;
    end else if (r_fv) begin
      if (r_cnt != '1)         r_cnt <= r_cnt + 1'b1;
      if (r_f && (r_err != '1)) r_err <= r_err + 1'b1;
      if (r_hd > r_max)        r_max <= r_hd;
      r_sum <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
      r_any <= r_any | r_f;
    end
  end

  assign f_valid    = r_fv;
  assign f          = r_f;
  assign hd         = r_hd;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = r_done;
  assign any_err    = r_any;
  assign sample_cnt = r_cnt;
  assign err_cnt    = r_err;
  assign max_hd     = r_max;
  assign hd_sum     = r_sum;

endmodule

`default_nettype wire
